adder_sum_accumulator: RTL
==========================

Name: adder_sum_accumulator

Overview:
Downstream consumer of the registered adder output. Accepts a run of num_terms sums, one per cycle when sum_valid is high, and accumulates them into a wider register. It then presents the total with a valid/ready handshake. Used to stress adder chains in benchmark circuits and to give the sum bus a sequential sink so it cannot be optimised away.

Parameters:
ADDER_WIDTH, 5, operand width of the upstream adder; the sum input is ADDER_WIDTH+1 bits.
ACC_WIDTH, 16, accumulator width; must be >= ADDER_WIDTH+1.
COUNT_WIDTH, 8, width of the term counter and num_terms.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new accumulation run; sampled only in IDLE
num_terms  input  COUNT_WIDTH  number of sums to accumulate; sampled with start
sum_in  input  ADDER_WIDTH+1  unsigned sum from the upstream adder
sum_valid  input  1  sum_in is valid this cycle (no backpressure upstream)
acc_out  output  ACC_WIDTH  accumulated total; stable while acc_valid=1
acc_valid  output  1  result available
acc_ready  input  1  consumer accepts result
busy  output  1  high in ACCUM and DONE
overflow  output  1  sticky; accumulator wrapped during the current run

Behaviour:
- Reset (async assert, sync release to clk): state=IDLE; acc_out=0, acc_valid=0, busy=0, overflow=0, remaining=0.
- States: IDLE, ACCUM, DONE. All outputs are registered.
- IDLE:
  - start=1 with num_terms>0: next cycle acc_out=0, overflow=0, remaining=num_terms, state=ACCUM, busy=1.
  - start=1 with num_terms=0: next cycle acc_out=0, overflow=0, state=DONE, acc_valid=1.
  - sum_valid is ignored in IDLE.
- ACCUM:
  - On each cycle with sum_valid=1: acc_out <= acc_out + zero-extend(sum_in), modulo 2^ACC_WIDTH.
  - On that same cycle, overflow <= overflow | carry-out of that addition, and remaining decrements.
  - Cycles with sum_valid=0 leave all state unchanged (gaps allowed, no timeout).
  - When sum_valid=1 and remaining==1: state=DONE and acc_valid=1 on the next edge. The result appears 1 cycle after the last accepted term.
- DONE:
  - acc_valid=1; acc_out and overflow are held.
  - When acc_valid & acc_ready on a rising edge: next cycle acc_valid=0, busy=0, state=IDLE. acc_out and overflow keep their last values until the next start.
  - acc_ready may already be high on the cycle acc_valid rises; the handshake then completes on the next edge.
- start is ignored in ACCUM and DONE; a run is never restarted mid-flight.
- sum_valid in DONE is ignored; the excess terms are dropped and do not alter acc_out.
- The earliest next start is the cycle after returning to IDLE. There is a 1-cycle IDLE bubble minimum between runs.
- Reset mid-run: immediate return to IDLE with all outputs cleared; the partial total is discarded.
- num_terms = 2^COUNT_WIDTH-1 must work with no counter wrap issues.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, start=0 -> acc_out=0, acc_valid=0, busy=0, overflow=0 for 10 cycles.
- Basic run: start, num_terms=4; sums 10,20,30,40 on consecutive cycles; acc_ready=1 -> acc_valid high exactly 1 cycle after the 4th term, acc_out=100, overflow=0; IDLE next cycle.
- Gaps and backpressure: num_terms=3; sums 63, (gap 2 cycles), 63, 1; acc_ready held low 5 cycles -> acc_out=127 held stable with acc_valid=1 until acc_ready rises, then cleared.
- Overflow: ACC_WIDTH=8 build, num_terms=5, five sums of 63 -> acc_out=315 mod 256=59, overflow=1. A following run of 2 x 1 gives acc_out=2, overflow=0.
- Zero terms and ignored inputs: start with num_terms=0 -> acc_valid next cycle with acc_out=0. Extra sum_valid pulses and start pulses in ACCUM/DONE -> no effect on total or run.
- Reset mid-run: num_terms=10, assert rst_n low after 4 terms -> outputs 0 asynchronously. A new run of 2 x 5 after release yields acc_out=10.

Source files
------------

// File: rtl/adder_sum_accumulator_if.sv
// Bus bundle between the upstream adder and the sum accumulator.
// The master side drives the run request, the sums and acc_ready. The slave side returns the total.
interface adder_sum_accumulator_if #(
  parameter int ADDER_WIDTH = 5,
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] num_terms;
  logic [ADDER_WIDTH:0]   sum_in;
  logic                   sum_valid;
  logic [ACC_WIDTH-1:0]   acc_out;
  logic                   acc_valid;
  logic                   acc_ready;
  logic                   busy;
  logic                   overflow;

  modport master (
    output start, num_terms, sum_in, sum_valid, acc_ready,
    input  acc_out, acc_valid, busy, overflow
  );

  modport slave (
    input  start, num_terms, sum_in, sum_valid, acc_ready,
    output acc_out, acc_valid, busy, overflow
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates a run of num_terms adder sums into a wider register.
// The total is presented with a valid/ready handshake, and a sticky flag records any wrap during the run.
module adder_sum_accumulator #(
  parameter int ADDER_WIDTH = 5,
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adder_sum_accumulator_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]             state_r,     state_s;
  logic [COUNT_WIDTH-1:0] remaining_r, remaining_s;
  logic [ACC_WIDTH-1:0]   acc_r,       acc_s;
  logic                   acc_valid_r, acc_valid_s;
  logic                   busy_r,      busy_s;
  logic                   overflow_r,  overflow_s;
  logic [ACC_WIDTH:0]     wide_sum_s;

  // The extra top bit of the result is the carry out of the accumulator.
  function automatic logic [ACC_WIDTH:0] add_term(input logic [ACC_WIDTH-1:0] acc,
                                                  input logic [ADDER_WIDTH:0]  term);
    add_term = {1'b0, acc} + (ACC_WIDTH+1)'(term);
  endfunction

  // Next-state and next-output logic for the IDLE/ACCUM/DONE sequencer
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    acc_s       = acc_r;
    acc_valid_s = acc_valid_r;
    busy_s      = busy_r;
    overflow_s  = overflow_r;
    wide_sum_s  = add_term(acc_r, bus.sum_in);
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          acc_s      = {ACC_WIDTH{1'b0}};
          overflow_s = 1'b0;
          busy_s     = 1'b1;
          if (bus.num_terms != {COUNT_WIDTH{1'b0}}) begin
            remaining_s = bus.num_terms;
            state_s     = ST_ACCUM;
          end else begin
            acc_valid_s = 1'b1;
            state_s     = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bus.sum_valid) begin
          acc_s       = wide_sum_s[ACC_WIDTH-1:0];
          overflow_s  = overflow_r | wide_sum_s[ACC_WIDTH];
          remaining_s = remaining_r - COUNT_WIDTH'(1);
          if (remaining_r == COUNT_WIDTH'(1)) begin
            acc_valid_s = 1'b1;
            state_s     = ST_DONE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        // acc_out and overflow deliberately survive the handshake until the next start
        if (bus.acc_ready) begin
          acc_valid_s = 1'b0;
          busy_s      = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        acc_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= {COUNT_WIDTH{1'b0}};
      acc_r       <= {ACC_WIDTH{1'b0}};
      acc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      acc_r       <= acc_s;
      acc_valid_r <= acc_valid_s;
      busy_r      <= busy_s;
      overflow_r  <= overflow_s;
    end
  end

  assign bus.acc_out   = acc_r;
  assign bus.acc_valid = acc_valid_r;
  assign bus.busy      = busy_r;
  assign bus.overflow  = overflow_r;

endmodule
